regfile_bist: RTL and testbench
===============================

Name: regfile_bist

Overview:
Built-in self-test controller that drives the write and dual read ports of the 32x32 register file (Regfiles) as their initiator.
- Fills every register with an address-derived pattern, then reads all registers back on both read ports at once and compares against expected values.
- Reports pass/fail, a mismatch count and the first failing address.
- Sits beside Regfiles in the CPU top and shares the regfile port signals through a mux selected by busy.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NREGS, 32, number of registers tested; must be even and equal to 2**ADDR_W.
- SEED, 32'h1, pattern base; expected(a) = SEED + a, truncated to DATA_W.
- R0_ZERO, 1, when 1, register 0 is hardwired zero and its expected value is 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- busy  out  1  high while in WR or RD.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  valid when done=1; 1 if err_cnt==0.
- err_cnt  out  ADDR_W+2  mismatch count; saturates at all-ones.
- first_fail_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- rf_we  out  1  regfile write enable.
- rf_waddr  out  ADDR_W  regfile write address.
- rf_wdata  out  DATA_W  regfile write data.
- rf_raddr1  out  ADDR_W  read port 1 address.
- rf_raddr2  out  ADDR_W  read port 2 address.
- rf_rdata1  in  DATA_W  read port 1 data; combinational (async read).
- rf_rdata2  in  DATA_W  read port 2 data; combinational (async read).

Behaviour:
- Reset: rst is synchronous and active-high. At the next clock edge the FSM goes to IDLE and all outputs return to 0 (rf_* included). This holds mid-run; no partial result is kept.
- States: IDLE, WR, RD, DONE. Single index counter idx, plus a pass flag inv.

State transitions:
- IDLE/DONE, start=1: go to WR; clear idx, inv, err_cnt, first_fail_addr, done, pass.
- WR: rf_we=1, rf_waddr=idx, rf_wdata=pat(idx). A write commits at each edge. After idx==NREGS-1, go to RD with idx=0.
- RD: rf_we=0, rf_raddr1=idx, rf_raddr2=NREGS-1-idx. On each edge compare rf_rdata1 with exp(idx) and rf_rdata2 with exp(NREGS-1-idx). After idx==NREGS-1, go to DONE (or to the second pass, see Optional Feature).
- DONE: done=1, pass=(err_cnt==0); rf_* driven to 0.

Pattern rules:
- pat(a) = SEED + a; XOR all-ones when inv=1.
- exp(a) = 0 when R0_ZERO && a==0, else pat(a).

Error reporting:
- A mismatch on both ports in the same cycle adds 2 to err_cnt; the two read addresses never coincide because NREGS is even.
- first_fail_addr is latched on the first mismatch only. If both ports fail in that same cycle, port 1's address wins.
- err_cnt saturates and does not wrap.

Timing and sequencing:
- Latency: start sampled at edge E0 gives done=1 after edge E0 + 2*NREGS (64 cycles at defaults).
- start during WR/RD is ignored.
- start in DONE restarts immediately.
- rst has priority over start.

Optional Feature:
- Macro: REGFILE_BIST_INV_PASS_EN.
- Defined: after the first RD completes, set inv=1 and re-enter WR then RD with the inverted pattern. err_cnt and first_fail_addr accumulate across both passes. Latency becomes 4*NREGS.
- Undefined: single pass only; the inv logic is absent.

Decomposition:
- Shared package regfile_bist_pkg holds the state encoding (IDLE=0, WR=1, RD=2, DONE=3) and the ADDR_W/DATA_W/NREGS defaults.
- One sub-module, regfile_bist_pattern, computes exp(a) from a, inv, SEED and R0_ZERO. It is instantiated three times: write data, port 1 expected, port 2 expected.

Test Plan:
All scenarios use a behavioural Regfiles model with r0 hardwired to zero and default parameters.
1. Fault-free model; pulse start -> writes addr a with a+1 for a=1..31; done=1 exactly 64 cycles later, pass=1, err_cnt=0, first_fail_addr=0.
2. Reg 5 bit0 stuck-at-1 (reads 7, expected 6) -> done at 64, pass=0, err_cnt=2 (port1 at idx 5, port2 at idx 26), first_fail_addr=5.
3. rst=1 for one cycle during WR at idx=10 -> next edge: rf_we=0, busy=0, done=0, err_cnt=0. A fresh start afterwards completes normally at 64 cycles.
4. Second start pulse 20 cycles into a run -> ignored; done at the original 64. Start pulse while in DONE -> busy=1 next cycle, done=0.
5. With REGFILE_BIST_INV_PASS_EN, reg 3 bit31 stuck-at-0 -> pass 1 clean (4); pass 2 expects ~4, reads bit31=0; done at 128, err_cnt=2, first_fail_addr=3.
6. R0_ZERO=0 against the hardwired-r0 model -> err_cnt=2, first_fail_addr=0, pass=0.

Source files
------------

// File: rtl/regfile_bist_pkg.sv
// Shared state encoding and default geometry for the register-file self-test controller.
package regfile_bist_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_bist_pattern.sv
// Address-derived test pattern: SEED + addr, inverted on the second pass; register 0 expects 0 when hardwired.
module regfile_bist_pattern #(
    parameter int               ADDR_W  = 5,
    parameter int               DATA_W  = 32,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(1),
    parameter bit               R0_ZERO = 1'b1
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              inv_i,
    output logic [DATA_W-1:0] exp_o
);

    logic [DATA_W-1:0] pat;

    assign pat   = (SEED + DATA_W'(addr_i)) ^ {DATA_W{inv_i}};
    assign exp_o = (R0_ZERO && (addr_i == '0)) ? '0 : pat;

endmodule

// File: rtl/regfile_bist.sv
// Self-test initiator for the 32x32 dual-read register file: fill, read back on both ports, count mismatches.
// Defining REGFILE_BIST_INV_PASS_EN adds a second fill/read pass with the inverted pattern.
module regfile_bist
    import regfile_bist_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                NREGS   = NREGS_DEF,
    parameter logic [DATA_W-1:0] SEED    = DATA_W'(1),
    parameter bit                R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_cnt,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2
);

    localparam int ERR_W = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NREGS - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [ERR_W-1:0]  err_cnt_d;
    logic [ADDR_W-1:0] ffa_q;
    logic              done_q;
    logic              pass_q;
    logic              inv;

`ifdef REGFILE_BIST_INV_PASS_EN
    logic              inv_q;
    assign inv = inv_q;
`else
    assign inv = 1'b0;
`endif

    logic [ADDR_W-1:0] idx2;
    logic              idx_last;
    logic              in_wr;
    logic              in_rd;
    logic [DATA_W-1:0] wpat;
    logic [DATA_W-1:0] exp1;
    logic [DATA_W-1:0] exp2;
    logic              mis1;
    logic              mis2;
    logic [ERR_W:0]    err_sum;

    // Port 2 walks downward so both ports cover every register in one sweep.
    assign idx2     = IDX_LAST - idx_q;
    assign idx_last = (idx_q == IDX_LAST);
    assign in_wr    = (state_q == WR);
    assign in_rd    = (state_q == RD);

    regfile_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED),
        .R0_ZERO(R0_ZERO)
    ) u_pat_wr (
        .addr_i(idx_q),
        .inv_i (inv),
        .exp_o (wpat)
    );

    regfile_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED),
        .R0_ZERO(R0_ZERO)
    ) u_pat_rd1 (
        .addr_i(idx_q),
        .inv_i (inv),
        .exp_o (exp1)
    );

    regfile_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED),
        .R0_ZERO(R0_ZERO)
    ) u_pat_rd2 (
        .addr_i(idx2),
        .inv_i (inv),
        .exp_o (exp2)
    );

    assign mis1 = in_rd && (rf_rdata1 != exp1);
    assign mis2 = in_rd && (rf_rdata2 != exp2);

    // Saturating add: one extra carry bit detects overflow.
    assign err_sum   = {1'b0, err_cnt_q} + {{ERR_W{1'b0}}, mis1} + {{ERR_W{1'b0}}, mis2};
    assign err_cnt_d = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            err_cnt_q <= '0;
            ffa_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
`ifdef REGFILE_BIST_INV_PASS_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= WR;
                        idx_q     <= '0;
                        err_cnt_q <= '0;
                        ffa_q     <= '0;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
`ifdef REGFILE_BIST_INV_PASS_EN
                        inv_q     <= 1'b0;
`endif
                    end
                end
                WR: begin
                    idx_q <= idx_last ? '0 : idx_q + ADDR_W'(1);
                    if (idx_last) begin
                        state_q <= RD;
                    end
                end
                RD: begin
                    err_cnt_q <= err_cnt_d;
                    // A zero count means nothing has failed yet; port 1 wins a same-cycle tie.
                    if ((err_cnt_q == '0) && (mis1 || mis2)) begin
                        ffa_q <= mis1 ? idx_q : idx2;
                    end
                    idx_q <= idx_last ? '0 : idx_q + ADDR_W'(1);
                    if (idx_last) begin
`ifdef REGFILE_BIST_INV_PASS_EN
                        if (!inv_q) begin
                            inv_q   <= 1'b1;
                            state_q <= WR;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == '0);
                        end
`else
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = in_wr || in_rd;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_fail_addr = ffa_q;
    assign rf_we           = in_wr;
    assign rf_waddr        = in_wr ? idx_q : '0;
    assign rf_wdata        = in_wr ? wpat : '0;
    assign rf_raddr1       = in_rd ? idx_q : '0;
    assign rf_raddr2       = in_rd ? idx2 : '0;

endmodule

// File: tb/tb_regfile_bist.sv
// Randomized scoreboard bench: two controllers (r0 expected zero / expected SEED) against hardwired-r0 register files with stuck-at faults.
module tb_regfile_bist;

    localparam int N    = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam logic [DW-1:0] SEED_V = 32'h1;
`ifdef REGFILE_BIST_INV_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int LAT = 2 * N * NPASS;

    typedef struct {
        int sc;
        int ec;
        int ffa;
        bit ps;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy  [2];
    logic          done  [2];
    logic          pass  [2];
    logic [AW+1:0] ec    [2];
    logic [AW-1:0] ffa   [2];
    logic          we    [2];
    logic [AW-1:0] waddr [2];
    logic [DW-1:0] wd    [2];
    logic [AW-1:0] ra1   [2];
    logic [AW-1:0] ra2   [2];
    logic [DW-1:0] rd1   [2];
    logic [DW-1:0] rd2   [2];

    logic [DW-1:0] mem   [2][N];
    logic [DW-1:0] or_m  [N];
    logic [DW-1:0] and_m [N];

    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;
    exp_t q0[$];
    exp_t q1[$];

    regfile_bist #(.R0_ZERO(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(ec[0]), .first_fail_addr(ffa[0]),
        .rf_we(we[0]), .rf_waddr(waddr[0]), .rf_wdata(wd[0]),
        .rf_raddr1(ra1[0]), .rf_raddr2(ra2[0]),
        .rf_rdata1(rd1[0]), .rf_rdata2(rd2[0])
    );

    regfile_bist #(.R0_ZERO(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(ec[1]), .first_fail_addr(ffa[1]),
        .rf_we(we[1]), .rf_waddr(waddr[1]), .rf_wdata(wd[1]),
        .rf_raddr1(ra1[1]), .rf_raddr2(ra2[1]),
        .rf_rdata1(rd1[1]), .rf_rdata2(rd2[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file models: r0 hardwired to zero, stuck-at faults applied on the storage.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (we[d] && waddr[d] != '0) mem[d][waddr[d]] <= wd[d];
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            rd1[d] = (ra1[d] == '0) ? '0 : ((mem[d][ra1[d]] | or_m[ra1[d]]) & and_m[ra1[d]]);
            rd2[d] = (ra2[d] == '0) ? '0 : ((mem[d][ra2[d]] | or_m[ra2[d]]) & and_m[ra2[d]]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pat(int a, bit inv);
        return (SEED_V + DW'(a)) ^ {DW{inv}};
    endfunction

    function automatic logic [DW-1:0] stored(int a, bit inv);
        if (a == 0) return '0;
        return (pat(a, inv) | or_m[a]) & and_m[a];
    endfunction

    function automatic logic [DW-1:0] expv(int a, bit inv, bit r0z);
        return (r0z && a == 0) ? '0 : pat(a, inv);
    endfunction

    function automatic exp_t model(bit r0z, int sc);
        exp_t e;
        bit   seen = 1'b0;
        bit   m1;
        bit   m2;
        e.sc  = sc;
        e.ec  = 0;
        e.ffa = 0;
        for (int p = 0; p < NPASS; p++) begin
            for (int i = 0; i < N; i++) begin
                m1 = stored(i, p == 1) != expv(i, p == 1, r0z);
                m2 = stored(N - 1 - i, p == 1) != expv(N - 1 - i, p == 1, r0z);
                if (!seen && (m1 || m2)) begin
                    e.ffa = m1 ? i : N - 1 - i;
                    seen  = 1'b1;
                end
                e.ec = e.ec + int'(m1) + int'(m2);
                if (e.ec > (1 << (AW + 2)) - 1) e.ec = (1 << (AW + 2)) - 1;
            end
        end
        e.ps = (e.ec == 0);
        return e;
    endfunction

    task automatic check_done(input int d);
        exp_t e;
        ncmp++;
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            nerr++;
            $display("FAIL unexpected_done dut%0d: done rose with an empty scoreboard (cycle %0d)", d, cyc);
            return;
        end
        ncmp--;
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("latency dut%0d", d), cyc - e.sc - 1, LAT);
        chk($sformatf("pass dut%0d", d), pass[d], e.ps);
        chk($sformatf("err_cnt dut%0d", d), ec[d], e.ec);
        chk($sformatf("first_fail_addr dut%0d", d), ffa[d], e.ffa);
    endtask

    // Monitor: checks the write stream and pops one scoreboard entry per completed run.
    initial begin
        bit pbusy [2];
        bit pdone [2];
        int wcnt  [2];
        for (int d = 0; d < 2; d++) begin
            pbusy[d] = 1'b0;
            pdone[d] = 1'b0;
            wcnt[d]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (busy[d] && !pbusy[d]) wcnt[d] = 0;
                if (we[d]) begin
                    chk($sformatf("waddr dut%0d", d), waddr[d], wcnt[d] % N);
                    if (waddr[d] != '0)
                        chk($sformatf("wdata dut%0d", d), wd[d], pat(wcnt[d] % N, wcnt[d] >= N));
                    wcnt[d]++;
                end
                if (done[d] && !pdone[d]) check_done(d);
                pbusy[d] = busy[d];
                pdone[d] = done[d];
            end
        end
    end

    task automatic clear_faults();
        for (int a = 0; a < N; a++) begin
            or_m[a]  = '0;
            and_m[a] = '1;
        end
    endtask

    task automatic go();
        @(negedge clk);
        q0.push_back(model(1'b1, cyc));
        q1.push_back(model(1'b0, cyc));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!(done[0] && done[1]) && k < 8 * N * NPASS) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", done[0] && done[1], 1);
    endtask

    initial begin
        int a;
        int b;
        rst   = 1'b1;
        start = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        chk("reset busy", busy[0], 0);
        chk("reset done", done[0], 0);
        chk("reset pass", pass[0], 0);
        chk("reset err_cnt", ec[0], 0);
        chk("reset ffa", ffa[0], 0);
        chk("reset rf_we", we[0], 0);
        chk("reset raddr2", ra2[0], 0);
        rst = 1'b0;

        // Fault-free run, then reg 5 bit0 stuck-at-1, then reg 3 bit31 stuck-at-0.
        go(); wait_done();
        or_m[5] = 32'h1;
        go(); wait_done();
        clear_faults();
        and_m[3] = 32'h7fff_ffff;
        go(); wait_done();
        clear_faults();

        // Reset in the middle of the write sweep abandons the run.
        go();
        repeat (10) @(negedge clk);
        chk("pre-reset busy", busy[0], 1);
        void'(q0.pop_back());
        void'(q1.pop_back());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun-reset rf_we", we[0], 0);
        chk("midrun-reset busy", busy[0], 0);
        chk("midrun-reset done", done[0], 0);
        chk("midrun-reset err_cnt", ec[1], 0);
        repeat (2) @(negedge clk);
        go(); wait_done();

        // Start while busy is ignored; start in DONE restarts at once.
        or_m[17] = 32'h100;
        go();
        repeat (19) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        go();
        chk("restart busy", busy[0], 1);
        chk("restart done", done[0], 0);
        wait_done();

        for (int r = 0; r < 8; r++) begin
            clear_faults();
            for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
                a = int'($urandom_range(1, N - 1));
                b = int'($urandom_range(0, DW - 1));
                if ($urandom_range(0, 1) == 1) or_m[a][b] = 1'b1;
                else and_m[a][b] = 1'b0;
            end
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
            go(); wait_done();
        end

        repeat (4) @(negedge clk);
        chk("scoreboard drained", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
